branch_predictor: RTL and testbench

- Fetch-stage branch predictor that consumes the branch resolution outcome (taken / not-taken plus target) produced by the condition-check logic.
- Holds a direct-mapped branch target buffer (BTB). Each entry has a tag, a target and a 2-bit saturating counter.
- Supplies a predicted next PC to fetch each cycle.
- When a resolved branch disagrees with its prediction, flags a mispredict and supplies the redirect PC for the pipeline flush.

---
 rtl/branch_predictor_pkg.sv | 25 ++
 rtl/branch_predictor_sat_counter2.sv | 19 +
 rtl/branch_predictor.sv | 105 ++++++++++
 tb/tb_branch_predictor.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared constants and encodings for the fetch-stage branch predictor
package branch_predictor_pkg;

    localparam int CNT_W  = 2;
    localparam int PC_INC = 4;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_cnt_e;

    typedef enum logic [1:0] {
        BR_NOT_BRANCH = 2'b00,
        BR_BEQ        = 2'b01,
        BR_BNE        = 2'b10
    } br_type_e;

    // Tag width left after removing the index bits and the two byte-offset bits.
    function automatic int tag_w(input int width, input int idx_bits);
        return width - idx_bits - 2;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// rtl/branch_predictor_sat_counter2.sv - 2-bit saturating up/down counter next-state function
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             up_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (up_i) begin
            if (cnt_i != ST) cnt_o = cnt_i + 2'd1;
        end else begin
            if (cnt_i != SNT) cnt_o = cnt_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters, mispredict detection and perf counters
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IDX_BITS  = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     fetch_pc,
    output logic                 pred_taken,
    output logic [WIDTH-1:0]     pred_target,
    input  logic                 upd_valid,
    input  logic [WIDTH-1:0]     upd_pc,
    input  logic                 upd_taken,
    input  logic [WIDTH-1:0]     upd_target,
    input  logic                 upd_pred_taken,
    input  logic [WIDTH-1:0]     upd_pred_target,
    output logic                 mispredict,
    output logic [WIDTH-1:0]     redirect_pc,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = tag_w(WIDTH, IDX_BITS);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [WIDTH-1:0]   target_q [ENTRIES];
    logic [CNT_W-1:0]   cnt_q    [ENTRIES];

    logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [IDX_BITS-1:0] fetch_idx, upd_idx;
    logic [TAG_W-1:0]    fetch_tag, upd_tag;
    logic                fetch_hit, upd_hit;
    logic [CNT_W-1:0]    cnt_d;

    assign fetch_idx = fetch_pc[IDX_BITS+1:2];
    assign fetch_tag = fetch_pc[WIDTH-1:IDX_BITS+2];
    assign upd_idx   = upd_pc[IDX_BITS+1:2];
    assign upd_tag   = upd_pc[WIDTH-1:IDX_BITS+2];

    // Lookup reads only registered state, so a same-cycle update is not visible here.
    assign fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign pred_taken  = fetch_hit && cnt_q[fetch_idx][1];
    assign pred_target = pred_taken ? target_q[fetch_idx] : fetch_pc + WIDTH'(PC_INC);

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
    assign redirect_pc = upd_taken ? upd_target : upd_pc + WIDTH'(PC_INC);

    sat_counter2 u_sat_counter2 (
        .cnt_i (cnt_q[upd_idx]),
        .up_i  (upd_taken),
        .cnt_o (cnt_d)
    );

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_valid && (branch_cnt_q != {CNT_WIDTH{1'b1}}))
            branch_cnt_d = branch_cnt_q + 1'b1;
        if (mispredict && (mispred_cnt_q != {CNT_WIDTH{1'b1}}))
            mispred_cnt_d = mispred_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= WNT;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            if (upd_valid) begin
                if (upd_hit) begin
                    cnt_q[upd_idx] <= cnt_d;
                end else if (upd_taken) begin
                    valid_q[upd_idx] <= 1'b1;
                    cnt_q[upd_idx]   <= WT;
                end
            end
        end
    end

    // Tags and targets carry no reset; they are qualified by valid_q.
    always_ff @(posedge clk) begin
        if (!rst && upd_valid && upd_taken) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - randomized and directed self-checking bench for branch_predictor
module tb_branch_predictor;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] fetch_pc, upd_pc, upd_target, upd_pred_target;
    logic        upd_valid, upd_taken, upd_pred_taken;

    logic        pred_taken, mispredict;
    logic [31:0] pred_target, redirect_pc, branch_cnt, mispred_cnt;
    logic        pred_taken4, mispredict4;
    logic [31:0] pred_target4, redirect_pc4;
    logic [3:0]  branch_cnt4, mispred_cnt4;

    branch_predictor dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    branch_predictor #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken4), .pred_target(pred_target4),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mispredict4),
        .redirect_pc(redirect_pc4), .branch_cnt(branch_cnt4), .mispred_cnt(mispred_cnt4)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_cnt   [16];
    longint      m_br, m_mp;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) & 32'hF);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc >> 6;
    endfunction

    function automatic bit exp_mp();
        return upd_valid && ((upd_taken != upd_pred_taken) ||
                             (upd_taken && upd_pred_taken && upd_target != upd_pred_target));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model_update
        int  i;
        bit  hit;
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                m_valid[k] = 0;
                m_cnt[k]   = 1;
            end
            m_br = 0;
            m_mp = 0;
        end else if (upd_valid) begin
            m_br++;
            if (exp_mp()) m_mp++;
            i   = idx_of(upd_pc);
            hit = m_valid[i] && (m_tag[i] == tag_of(upd_pc));
            if (hit && upd_taken) begin
                m_cnt[i] = (m_cnt[i] >= 3) ? 3 : m_cnt[i] + 1;
                m_tgt[i] = upd_target;
            end else if (hit) begin
                m_cnt[i] = (m_cnt[i] <= 0) ? 0 : m_cnt[i] - 1;
            end else if (upd_taken) begin
                m_valid[i] = 1;
                m_tag[i]   = tag_of(upd_pc);
                m_tgt[i]   = upd_target;
                m_cnt[i]   = 2;
            end
        end
    end

    always @(negedge clk) begin : compare
        int          i;
        bit          pt;
        logic [31:0] ptgt, rd, e32, e32m, e4, e4m;
        if (chk_en) begin
            i    = idx_of(fetch_pc);
            pt   = m_valid[i] && (m_tag[i] == tag_of(fetch_pc)) && (m_cnt[i] >= 2);
            ptgt = pt ? m_tgt[i] : fetch_pc + 32'd4;
            rd   = upd_taken ? upd_target : upd_pc + 32'd4;
            e32  = (m_br > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_br[31:0];
            e32m = (m_mp > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_mp[31:0];
            e4   = (m_br > 15) ? 32'd15 : m_br[31:0];
            e4m  = (m_mp > 15) ? 32'd15 : m_mp[31:0];
            chk("pred_taken", {31'd0, pred_taken}, {31'd0, pt});
            chk("pred_target", pred_target, ptgt);
            chk("mispredict", {31'd0, mispredict}, {31'd0, exp_mp()});
            if (upd_valid) chk("redirect_pc", redirect_pc, rd);
            chk("branch_cnt", branch_cnt, e32);
            chk("mispred_cnt", mispred_cnt, e32m);
            chk("pred_taken4", {31'd0, pred_taken4}, {31'd0, pt});
            chk("pred_target4", pred_target4, ptgt);
            chk("mispredict4", {31'd0, mispredict4}, {31'd0, exp_mp()});
            chk("branch_cnt4", {28'd0, branch_cnt4}, e4);
            chk("mispred_cnt4", {28'd0, mispred_cnt4}, e4m);
        end
    end

    task automatic drive(input bit r, input bit v, input logic [31:0] pc, input bit tk,
                         input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt,
                         input logic [31:0] fpc);
        @(posedge clk);
        #1;
        rst = r; upd_valid = v; upd_pc = pc; upd_taken = tk;
        upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt; fetch_pc = fpc;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [25:0] tg;
        logic [3:0]  ix;
        logic [1:0]  lo;
        case ($urandom_range(0, 3))
            0:       tg = 26'h1;
            1:       tg = 26'h2;
            2:       tg = 26'h3FF_FFFF;
            default: tg = 26'($urandom);
        endcase
        ix = 4'($urandom);
        lo = 2'($urandom);
        return {tg, ix, lo};
    endfunction

    initial begin
        rst = 1; upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
        upd_pred_taken = 0; upd_pred_target = 0; fetch_pc = 32'h0040_0010;
        @(posedge clk);
        #1;
        chk_en = 1;
        at_neg();
        chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("rst_pred_target", pred_target, 32'h0040_0014);
        chk("rst_branch_cnt", branch_cnt, 32'd0);
        chk("rst_mispred_cnt", mispred_cnt, 32'd0);

        drive(0, 1, 32'h0040_0010, 1, 32'h0040_0100, 0, 32'h0, 32'h0040_0010);
        at_neg();
        chk("alloc_mispredict", {31'd0, mispredict}, 32'd1);
        chk("alloc_redirect", redirect_pc, 32'h0040_0100);
        drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0040_0010);
        at_neg();
        chk("alloc_pred_taken", {31'd0, pred_taken}, 32'd1);
        chk("alloc_pred_target", pred_target, 32'h0040_0100);
        chk("alloc_branch_cnt", branch_cnt, 32'd1);
        chk("alloc_mispred_cnt", mispred_cnt, 32'd1);

        drive(0, 1, 32'h0040_0010, 0, 32'h0, 1, 32'h0040_0100, 32'h0040_0010);
        at_neg();
        chk("nt1_mispredict", {31'd0, mispredict}, 32'd1);
        chk("nt1_redirect", redirect_pc, 32'h0040_0014);
        drive(0, 1, 32'h0040_0010, 0, 32'h0, 0, 32'h0, 32'h0040_0010);
        at_neg();
        chk("nt1_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("nt2_mispredict", {31'd0, mispredict}, 32'd0);
        drive(0, 1, 32'h0040_0010, 0, 32'h0, 0, 32'h0, 32'h0040_0010);
        drive(0, 1, 32'h0040_0010, 1, 32'h0040_0100, 0, 32'h0, 32'h0040_0010);
        drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0040_0010);
        at_neg();
        chk("sat0_pred_taken", {31'd0, pred_taken}, 32'd0);

        drive(0, 1, 32'h0040_0010, 1, 32'h0040_0100, 0, 32'h0, 32'h0040_0010);
        drive(0, 1, 32'h0080_0010, 1, 32'h0080_0200, 0, 32'h0, 32'h0040_0010);
        drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0040_0010);
        at_neg();
        chk("alias_old_taken", {31'd0, pred_taken}, 32'd0);
        chk("alias_old_target", pred_target, 32'h0040_0014);
        drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0080_0010);
        at_neg();
        chk("alias_new_taken", {31'd0, pred_taken}, 32'd1);
        chk("alias_new_target", pred_target, 32'h0080_0200);

        drive(0, 1, 32'h0040_0020, 1, 32'h0040_0300, 0, 32'h0, 32'h0040_0020);
        at_neg();
        chk("hazard_same_cycle", {31'd0, pred_taken}, 32'd0);
        drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0040_0020);
        at_neg();
        chk("hazard_next_cycle", {31'd0, pred_taken}, 32'd1);
        chk("hazard_target", pred_target, 32'h0040_0300);

        drive(1, 1, 32'h0040_0030, 1, 32'h0040_0400, 0, 32'h0, 32'h0040_0030);
        drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0040_0030);
        at_neg();
        chk("rstupd_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("rstupd_branch_cnt", branch_cnt, 32'd0);
        chk("rstupd_mispred_cnt", mispred_cnt, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] t;
            t = rand_pc() & 32'hFFFF_FFFC;
            drive(($urandom_range(0, 199) == 0), 1'($urandom), rand_pc(), 1'($urandom), t,
                  1'($urandom), ($urandom_range(0, 1) != 0) ? t : (rand_pc() & 32'hFFFF_FFFC),
                  rand_pc());
        end

        drive(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0040_0010);
        for (int n = 0; n < 20; n++)
            drive(0, 1, 32'h0040_0040, 0, 32'h0, 1, 32'h0040_0500, 32'h0040_0040);
        drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0040_0040);
        at_neg();
        chk("sat4_branch_cnt", {28'd0, branch_cnt4}, 32'd15);
        chk("sat4_mispred_cnt", {28'd0, mispred_cnt4}, 32'd15);
        chk("sat32_branch_cnt", branch_cnt, 32'd20);
        chk("sat32_mispred_cnt", mispred_cnt, 32'd20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
